// File: rtl/sd_cmd_ctrl.sv
// SD command-line engine: serialises a 48-bit command with CRC7 on CMD and captures the response.
// Optional build macro SD_CMD_IDX_CHECK_EN adds response index / transmission-bit checking for R1-type responses.
module sd_cmd_ctrl #(
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC_MIN = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sdclk_fall_i,
    input  logic         sdclk_rise_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    input  logic         cmd_i,
    output logic         done_o,
    output logic [127:0] resp_o,
    output logic         crc_err_o,
    output logic         timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_WAIT,
        ST_RX,
        ST_GAP
    } state_t;

    localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);
    localparam logic [15:0] NCC_LOAD = 16'(NCC_MIN);
    localparam logic [15:0] TX_BITS  = 16'd48;
    localparam logic [15:0] RX_LAST_SHORT = 16'd46;
    localparam logic [15:0] RX_LAST_LONG  = 16'd134;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [47:0]    tx_sr_q, tx_sr_d;
    logic [126:0]   rx_sr_q, rx_sr_d;
    logic [1:0]     type_q, type_d;
    logic           cmd_q, cmd_d;
    logic           oe_q, oe_d;
    logic           done_q, done_d;
    logic [127:0]   resp_q, resp_d;
    logic           crc_err_q, crc_err_d;
    logic           timeout_q, timeout_d;
`ifdef SD_CMD_IDX_CHECK_EN
    logic [5:0]     idx_q, idx_d;
`endif

    logic           fall_s;
    logic           rise_s;
    logic [127:0]   rx_shift;
    logic [6:0]     rx_crc;
    logic [15:0]    rx_last;
    logic           rx_bad;

    // CRC7, polynomial x^7 + x^3 + 1, MSB-first over 40 bits, initial value zero.
    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0]  c;
        logic [39:0] dd;
        logic        fb;
        c  = '0;
        dd = d;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = dd[39] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
            dd = {dd[38:0], 1'b0};
        end
        return c;
    endfunction

    // A coincident fall strobe is dropped so the rise is handled alone.
    assign fall_s = sdclk_fall_i & ~sdclk_rise_i;
    assign rise_s = sdclk_rise_i;

    assign rx_shift = {rx_sr_q, cmd_i};
    assign rx_crc   = crc7_40({1'b0, rx_shift[46:8]});
    assign rx_last  = (type_q == 2'b10) ? RX_LAST_LONG : RX_LAST_SHORT;

    always_comb begin
        rx_bad = (rx_crc != rx_shift[7:1]) || !rx_shift[0];
`ifdef SD_CMD_IDX_CHECK_EN
        rx_bad = rx_bad || (rx_shift[45:40] != idx_q) || rx_shift[46];
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        type_d    = type_q;
        cmd_d     = cmd_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        crc_err_d = crc_err_q;
        timeout_d = timeout_q;
`ifdef SD_CMD_IDX_CHECK_EN
        idx_d     = idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    type_d    = resp_type_i;
                    tx_sr_d   = {2'b01, cmd_index_i, cmd_arg_i,
                                 crc7_40({2'b01, cmd_index_i, cmd_arg_i}), 1'b1};
                    rx_sr_d   = '0;
                    resp_d    = '0;
                    crc_err_d = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_TX;
`ifdef SD_CMD_IDX_CHECK_EN
                    idx_d     = cmd_index_i;
`endif
                end
            end

            ST_TX: begin
                if (fall_s) begin
                    if (cnt_q < TX_BITS) begin
                        cmd_d   = tx_sr_q[47];
                        oe_d    = 1'b1;
                        tx_sr_d = {tx_sr_q[46:0], 1'b0};
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        // End bit has now been held for a full SDCLK period.
                        cmd_d = 1'b1;
                        oe_d  = 1'b0;
                        if (type_q != 2'b00) begin
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end else begin
                            done_d  = 1'b1;
                            cnt_d   = NCC_LOAD;
                            state_d = ST_GAP;
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (rise_s) begin
                    if (!cmd_i) begin
                        cnt_d   = '0;
                        state_d = ST_RX;
                    end else if (cnt_q == NCR_LAST) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        cnt_d     = NCC_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            ST_RX: begin
                if (rise_s) begin
                    rx_sr_d = rx_shift[126:0];
                    if (cnt_q == rx_last) begin
                        done_d  = 1'b1;
                        cnt_d   = NCC_LOAD;
                        state_d = ST_GAP;
                        if (type_q == 2'b10) begin
                            resp_d = rx_shift;
                        end else begin
                            resp_d = {90'b0, rx_shift[45:8]};
                        end
                        if (type_q == 2'b01) begin
                            crc_err_d = rx_bad;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            ST_GAP: begin
                if (fall_s) begin
                    if (cnt_q <= 16'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end

            default: begin
                cnt_d   = NCC_LOAD;
                state_d = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_GAP;
            cnt_q     <= NCC_LOAD;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            type_q    <= '0;
            cmd_q     <= 1'b1;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
            crc_err_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef SD_CMD_IDX_CHECK_EN
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            type_q    <= type_d;
            cmd_q     <= cmd_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            crc_err_q <= crc_err_d;
            timeout_q <= timeout_d;
`ifdef SD_CMD_IDX_CHECK_EN
            idx_q     <= idx_d;
`endif
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign cmd_o       = cmd_q;
    assign cmd_oe_o    = oe_q;
    assign done_o      = done_q;
    assign resp_o      = resp_q;
    assign crc_err_o   = crc_err_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: command serialisation, response capture, CRC, timeout and reset cases.
module tb_sd_cmd_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         sdclk_fall_i = 1'b0;
    logic         sdclk_rise_i = 1'b0;
    logic         cmd_valid_i = 1'b0;
    logic         cmd_ready_o;
    logic [5:0]   cmd_index_i = '0;
    logic [31:0]  cmd_arg_i = '0;
    logic [1:0]   resp_type_i = '0;
    logic         cmd_o;
    logic         cmd_oe_o;
    logic         cmd_i = 1'b1;
    logic         done_o;
    logic [127:0] resp_o;
    logic         crc_err_o;
    logic         timeout_o;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    logic [47:0]  frame;
    logic         oe_all;
    logic [135:0] r2_bits;
    logic [135:0] r48;
    int           rises;
    int           done_before;
    logic         found;

    sd_cmd_ctrl #(.NCR_MAX(64), .NCC_MIN(8)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .sdclk_fall_i(sdclk_fall_i),
        .sdclk_rise_i(sdclk_rise_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_index_i(cmd_index_i),
        .cmd_arg_i(cmd_arg_i),
        .resp_type_i(resp_type_i),
        .cmd_o(cmd_o),
        .cmd_oe_o(cmd_oe_o),
        .cmd_i(cmd_i),
        .done_o(done_o),
        .resp_o(resp_o),
        .crc_err_o(crc_err_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (done_o) done_seen++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    task automatic fall_strobe();
        @(negedge clk_i);
        sdclk_fall_i = 1'b1;
        @(negedge clk_i);
        sdclk_fall_i = 1'b0;
    endtask

    task automatic rise_strobe();
        @(negedge clk_i);
        sdclk_rise_i = 1'b1;
        @(negedge clk_i);
        sdclk_rise_i = 1'b0;
    endtask

    task automatic accept(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t);
        @(negedge clk_i);
        chk("ready_before_accept", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_index_i = i;
        cmd_arg_i   = a;
        resp_type_i = t;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_index_i = 6'($urandom);
        cmd_arg_i   = $urandom;
        resp_type_i = 2'($urandom);
        chk("ready_drop", cmd_ready_o, 0);
        chk("resp_clear", resp_o, 0);
        chk("crc_err_clear", crc_err_o, 0);
        chk("timeout_clear", timeout_o, 0);
    endtask

    task automatic send(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                        output logic [47:0] fr, output logic oe_ok);
        accept(i, a, t);
        fr = '0;
        oe_ok = 1'b1;
        for (int b = 0; b < 48; b++) begin
            fall_strobe();
            fr = {fr[46:0], cmd_o};
            oe_ok = oe_ok & cmd_oe_o;
            rise_strobe();
        end
        fall_strobe();
        chk("release_oe", cmd_oe_o, 0);
        chk("release_cmd", cmd_o, 1);
    endtask

    task automatic respond(input logic [135:0] bits, input int n, input int delay);
        for (int d = 0; d < delay; d++) begin
            cmd_i = 1'b1;
            rise_strobe();
            fall_strobe();
        end
        for (int k = n - 1; k >= 0; k--) begin
            cmd_i = bits[k];
            rise_strobe();
            if (k > 0) fall_strobe();
        end
        cmd_i = 1'b1;
    endtask

    task automatic gap();
        for (int g = 0; g < 7; g++) begin
            fall_strobe();
            rise_strobe();
        end
        chk("gap_not_ready", cmd_ready_o, 0);
        fall_strobe();
        chk("gap_ready", cmd_ready_o, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_oe", cmd_oe_o, 0);
        chk("rst_cmd", cmd_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_resp", resp_o, 0);
        chk("rst_crc", crc_err_o, 0);
        chk("rst_timeout", timeout_o, 0);
        rst_i = 1'b0;
        gap();
        chk("idle_oe", cmd_oe_o, 0);
        chk("idle_cmd", cmd_o, 1);

        // CMD0, no response
        send(6'd0, 32'h0, 2'b00, frame, oe_all);
        chk("cmd0_frame", frame, 48'h400000000095);
        chk("cmd0_oe", oe_all, 1);
        chk("cmd0_done", done_o, 1);
        chk("cmd0_crc", crc_err_o, 0);
        chk("cmd0_timeout", timeout_o, 0);
        gap();

        // CMD8, good R7
        send(6'd8, 32'h1AA, 2'b01, frame, oe_all);
        chk("cmd8_frame", frame, 48'h48000001AA87);
        chk("cmd8_oe", oe_all, 1);
        respond(136'h08000001AA13, 48, 5);
        chk("cmd8_done", done_o, 1);
        chk("cmd8_resp", resp_o, 128'h08000001AA);
        chk("cmd8_crc", crc_err_o, 0);
        chk("cmd8_timeout", timeout_o, 0);
        gap();

        // CMD8, wrong CRC
        send(6'd8, 32'h1AA, 2'b01, frame, oe_all);
        respond(136'h08000001AA15, 48, 5);
        chk("badcrc_done", done_o, 1);
        chk("badcrc_crc", crc_err_o, 1);
        chk("badcrc_resp", resp_o, 128'h08000001AA);
        gap();

        // CMD8, end bit 0
        send(6'd8, 32'h1AA, 2'b01, frame, oe_all);
        respond(136'h08000001AA12, 48, 2);
        chk("endbit_crc", crc_err_o, 1);
        gap();

`ifdef SD_CMD_IDX_CHECK_EN
        send(6'd8, 32'h1AA, 2'b01, frame, oe_all);
        r48 = '0;
        r48[47:0] = {8'h09, 32'h1AA, ref_crc7({8'h09, 32'h1AA}), 1'b1};
        respond(r48, 48, 3);
        chk("idx_crc", crc_err_o, 1);
        gap();
`endif

        // CMD55, no response -> timeout
        send(6'd55, 32'h0, 2'b01, frame, oe_all);
        found = 1'b0;
        rises = 0;
        cmd_i = 1'b1;
        for (int r = 1; r <= 100 && !found; r++) begin
            rise_strobe();
            if (done_o) begin
                found = 1'b1;
                rises = r;
            end else begin
                fall_strobe();
            end
        end
        chk("to_rises", rises, 64);
        chk("to_timeout", timeout_o, 1);
        chk("to_resp", resp_o, 0);
        chk("to_crc", crc_err_o, 0);
        gap();

        // CMD2, R2 with corrupted CRC
        r2_bits = {2'b00, 6'h3F, 128'hDEADBEEF_01234567_89ABCDEF_5A5AA5A5};
        r2_bits[7:1] = ~ref_crc7(r2_bits[127:88]);
        send(6'd2, 32'h0, 2'b10, frame, oe_all);
        chk("cmd2_frame", frame, {8'h42, 32'h0, ref_crc7({8'h42, 32'h0}), 1'b1});
        respond(r2_bits, 136, 3);
        chk("r2_done", done_o, 1);
        chk("r2_resp", resp_o, r2_bits[127:0]);
        chk("r2_crc", crc_err_o, 0);
        chk("r2_timeout", timeout_o, 0);
        gap();

        // Reset mid-TX
        done_before = done_seen;
        accept(6'd2, 32'h0, 2'b10);
        for (int b = 0; b < 20; b++) begin
            fall_strobe();
            rise_strobe();
        end
        chk("midtx_oe_on", cmd_oe_o, 1);
        #1 rst_i = 1'b1;
        #1;
        chk("midtx_oe_off", cmd_oe_o, 0);
        chk("midtx_cmd", cmd_o, 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("midtx_ready", cmd_ready_o, 0);
        chk("midtx_nodone", done_seen, done_before);
        gap();

        // Reset mid-RX
        send(6'd2, 32'h0, 2'b10, frame, oe_all);
        done_before = done_seen;
        for (int d = 0; d < 3; d++) begin
            cmd_i = 1'b1;
            rise_strobe();
            fall_strobe();
        end
        for (int k = 135; k > 75; k--) begin
            cmd_i = r2_bits[k];
            rise_strobe();
            fall_strobe();
        end
        cmd_i = 1'b1;
        #1 rst_i = 1'b1;
        #1;
        chk("midrx_oe", cmd_oe_o, 0);
        chk("midrx_resp", resp_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrx_nodone", done_seen, done_before);
        chk("midrx_ready", cmd_ready_o, 0);
        gap();
        chk("final_oe", cmd_oe_o, 0);
        chk("final_cmd", cmd_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_cmd_ctrl.md
Name: sd_cmd_ctrl

Overview:
- SD command-line engine. Sits directly downstream of the SDCLK prescaler and consumes its SDCLK edge strobes.
- Serialises a 48-bit command frame with a generated CRC7 onto CMD.
- Then optionally captures a 48-bit or 136-bit response, checks CRC7, and reports timeout.
- Runs entirely in the clk_i domain. SDCLK is used only through one-cycle edge strobes.

Parameters:
- NCR_MAX, 64, maximum number of SDCLK rising strobes to wait for a response start bit after CMD is released.
- NCC_MIN, 8, number of idle SDCLK cycles forced after each transaction before cmd_ready_o reasserts.

Ports:
- clk_i  input  1  system clock; the only clock.
- rst_i  input  1  reset, asynchronous, active-high.
- sdclk_fall_i  input  1  one-cycle strobe at each SDCLK falling edge; CMD is driven on this strobe.
- sdclk_rise_i  input  1  one-cycle strobe at each SDCLK rising edge; CMD is sampled on this strobe.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  engine idle; the request is accepted when valid and ready are both high.
- cmd_index_i  input  6  command index.
- cmd_arg_i  input  32  command argument.
- resp_type_i  input  2  00 none, 01 R1/R6/R7 (48 bit, CRC checked), 10 R2 (136 bit), 11 R3 (48 bit, no CRC).
- cmd_o  output  1  CMD output value.
- cmd_oe_o  output  1  CMD output enable (pad tristate control).
- cmd_i  input  1  CMD pad input.
- done_o  output  1  one-cycle pulse at transaction end.
- resp_o  output  128  captured response.
- crc_err_o  output  1  valid with done_o.
- timeout_o  output  1  valid with done_o.

Behaviour:
- Reset values: cmd_ready_o=0 until the first NCC gap completes; cmd_o=1; cmd_oe_o=0; done_o=0; resp_o=0; crc_err_o=0; timeout_o=0; state=GAP with counter=NCC_MIN.
- Handshake: on accept, latch index, arg and resp_type. cmd_ready_o drops the next cycle. Inputs are don't-care afterwards.
- State TX:
  - Frame = {0, 1, index, arg, crc7, 1}, MSB first.
  - CRC7 polynomial x^7+x^3+1, computed over the first 40 bits, initial value 0.
  - Each sdclk_fall_i shifts out one bit. cmd_oe_o=1 from the first fall strobe after accept.
  - After the 48th bit has been held for one SDCLK period (the next fall strobe): cmd_oe_o=0, cmd_o=1.
  - Then go to WAIT if resp_type!=00, else GAP.
- State WAIT:
  - Count sdclk_rise_i strobes.
  - cmd_i==0 sampled on a rise strobe means start bit: go to RX.
  - Count reaching NCR_MAX with no start bit: timeout_o=1, done_o pulse, go to GAP.
- State RX:
  - Shift cmd_i on each rise strobe: 47 further bits for 48-bit responses, 135 for R2.
  - 48-bit responses: resp_o[37:0] = frame bits [45:8] ({index, arg}); resp_o[127:38]=0.
  - R2: resp_o[127:0] = frame bits [127:0] (bit 0 is the end bit).
  - For resp_type 01, crc_err_o=1 if the received CRC7 differs from the CRC over frame bits [47:8], or if the end bit is 0.
  - R2 and R3 never set crc_err_o.
  - After the last bit: done_o pulse, go to GAP.
- State GAP: count NCC_MIN fall strobes, then go to IDLE. cmd_ready_o=1 in IDLE only.
- Output hold: resp_o, crc_err_o and timeout_o hold their values until the next accept, then clear.
- Strobes:
  - If no strobe arrives, the FSM stalls; no timeout is counted in clk_i cycles.
  - Simultaneous rise and fall strobes are illegal. The block must not hang: rise is processed first.
- Reset mid-transaction: CMD is released the same cycle (async), no done_o pulse, and the full GAP is applied.

Optional Feature:
- Macro: SD_CMD_IDX_CHECK_EN.
- Defined: for resp_type 01, crc_err_o is also set when the response index differs from the latched command index, or the transmission bit is not 0.
- Undefined: only the CRC7 and end bit are checked; the compare logic is absent.

Test Plan:
- Reset, then strobes: after 8 fall strobes cmd_ready_o=1. cmd_oe_o=0 and cmd_o=1 throughout.
- CMD0, arg 0x00000000, type 00 -> cmd_o serialises 0x400000000095; done_o is 1 at the GAP entry and crc_err_o=0.
- CMD8, arg 0x000001AA, type 01 -> frame 0x48000001AA87. Bench returns 0x08000001AA13 after 5 rise strobes.
  - Required: resp_o[37:0]=0x08000001AA, crc_err_o=0, timeout_o=0.
- Same command, response last byte 0x15 -> crc_err_o=1.
  - With SD_CMD_IDX_CHECK_EN and response index 0x09 (correct CRC) -> crc_err_o=1.
- CMD55, type 01, CMD held high -> done_o after exactly 64 rise strobes, with timeout_o=1 and resp_o=0.
- CMD2, type 10, bench returns a 136-bit R2 -> resp_o equals frame bits [127:0], and crc_err_o=0 even with a corrupted CRC.
  - Assert rst_i mid-RX in a repeat run -> cmd_oe_o=0 immediately and no done_o.
